// File: rtl/wave_player_if.sv
// wave_player_if: handshake, control and ROM bus of the waveform player.
// The master side is the host/consumer environment: it issues start/stop,
// supplies the ROM data and accepts samples. The slave side is wave_player.
interface wave_player_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int CNT_W  = 16
) ();
    localparam int PH_W = ADDR_W + FRAC_W;

    logic              start;
    logic              stop;
    logic [PH_W-1:0]   step;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output stop,
        output step,
        output count,
        output rom_data,
        output sample_ready,
        input  rom_addr,
        input  sample,
        input  sample_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        input  step,
        input  count,
        input  rom_data,
        input  sample_ready,
        output rom_addr,
        output sample,
        output sample_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/wave_player.sv
// wave_player: sequential reader for the 8-bit waveform ROM.
// A fixed-point phase accumulator (ADDR_W integer + FRAC_W fractional bits)
// addresses the ROM; each fetched byte is presented on a valid/ready stream.
// States: IDLE -> FETCH (ROM settles one full cycle) -> HOLD (wait for accept).
// Optional build macro WAVE_PLAYER_LOOP_EN: continuous playback, the sample
// counter reloads at the end of each period and the phase keeps running
// until stop. Without the macro, each start plays exactly count samples.
module wave_player #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    wave_player_if.slave bus
);
    localparam int PH_W = ADDR_W + FRAC_W;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx;
    logic [PH_W-1:0]   phase_r;
    logic [PH_W-1:0]   phase_nx;
    logic [PH_W-1:0]   step_r;
    logic [PH_W-1:0]   step_nx;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nx;
    logic [CNT_W-1:0]  remaining_r;
    logic [CNT_W-1:0]  remaining_nx;
    logic [DATA_W-1:0] sample_r;
    logic [DATA_W-1:0] sample_nx;
    logic              valid_r;
    logic              valid_nx;
    logic              done_r;
    logic              done_nx;
    logic              busy_r;
    logic              handshake_s;

    // The sample is taken by the consumer at an edge where both sides agree.
    assign handshake_s = valid_r & bus.sample_ready;

    // Address is the integer part of the registered phase, so it only moves
    // when the phase register moves (leaving FETCH, start, stop or reset).
    assign bus.rom_addr     = phase_r[PH_W-1:FRAC_W];
    assign bus.sample       = sample_r;
    assign bus.sample_valid = valid_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and datapath next values; stop overrides everything.
    always_comb begin
        state_nx     = state_r;
        phase_nx     = phase_r;
        step_nx      = step_r;
        count_nx     = count_r;
        remaining_nx = remaining_r;
        sample_nx    = sample_r;
        valid_nx     = valid_r;
        done_nx      = 1'b0;

        if (bus.stop) begin
            state_nx     = ST_IDLE;
            valid_nx     = 1'b0;
            phase_nx     = PH_ZERO;
            remaining_nx = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        step_nx      = bus.step;
                        count_nx     = bus.count;
                        phase_nx     = PH_ZERO;
                        remaining_nx = bus.count;
                        if (bus.count != CNT_ZERO) begin
                            state_nx = ST_FETCH;
                        end else begin
                            // Empty run: no samples, just the completion pulse.
                            state_nx = ST_IDLE;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end

                ST_FETCH: begin
                    sample_nx    = bus.rom_data;
                    valid_nx     = 1'b1;
                    phase_nx     = phase_r + step_r;
                    remaining_nx = remaining_r - CNT_ONE;
                    state_nx     = ST_HOLD;
                end

                ST_HOLD: begin
                    if (handshake_s) begin
                        valid_nx = 1'b0;
                        if (remaining_r != CNT_ZERO) begin
                            state_nx = ST_FETCH;
                        end else begin
                            done_nx = 1'b1;
`ifdef WAVE_PLAYER_LOOP_EN
                            // Period complete: reload and keep the phase running.
                            remaining_nx = count_r;
                            state_nx     = ST_FETCH;
`else
                            state_nx     = ST_IDLE;
`endif
                        end
                    end else begin
                        state_nx = ST_HOLD;
                    end
                end

                default: begin
                    state_nx     = ST_IDLE;
                    valid_nx     = 1'b0;
                    phase_nx     = PH_ZERO;
                    remaining_nx = CNT_ZERO;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r     <= PH_ZERO;
            step_r      <= PH_ZERO;
            count_r     <= CNT_ZERO;
            remaining_r <= CNT_ZERO;
            sample_r    <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            phase_r     <= phase_nx;
            step_r      <= step_nx;
            count_r     <= count_nx;
            remaining_r <= remaining_nx;
            sample_r    <= sample_nx;
            valid_r     <= valid_nx;
            done_r      <= done_nx;
            busy_r      <= (state_nx != ST_IDLE);
        end
    end
endmodule
